// File: rtl/tl_monitor.sv
// tl_monitor: checks traffic-light lamp outputs against the legal phase cycle and dwell times; optional TLMON_DEGLITCH_EN
`timescale 1ns/1ps
module tl_monitor #(
  parameter int T_WIDTH = 12,
  parameter int NS_TIME = 90,
  parameter int EW_TIME = 60,
  parameter int Y_TIME  = 30,
  parameter int TOL     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_clr,
  input  logic [5:0]         i_lamps,
  output logic [2:0]         o_state,
  output logic               o_change,
  output logic [T_WIDTH-1:0] o_phase_time,
  output logic               o_fault,
  output logic [2:0]         o_fault_code
);
  typedef enum logic [1:0] {WAIT, FIRST, CHECK} fsm_t;
  localparam logic [2:0] C_ST = 3'b111, C_NS = 3'b011, C_NY = 3'b010, C_EW = 3'b000, C_EY = 3'b001;
  localparam logic [T_WIDTH-1:0] NS_T = T_WIDTH'(NS_TIME), EW_T = T_WIDTH'(EW_TIME), Y_T = T_WIDTH'(Y_TIME), TOL_T = T_WIDTH'(TOL);
  fsm_t fsm_q, fsm_d;
  logic [5:0] lamps_q;
  logic [2:0] state_q, state_d, code_q, code_d, dec, nxt, ncode;
  logic [T_WIDTH-1:0] cnt_q, cnt_d, exp_t;
  logic change_q, fault_q, fault_d, legal, smp_vld, acc, chk_en, f1, f2, f3, f4;
`ifdef TLMON_DEGLITCH_EN
  logic [5:0] prev_q;
  logic [1:0] vld_q;
  // second sample stage: a pattern counts only once it is seen twice in a row
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      prev_q <= '0;
      vld_q  <= '0;
    end else begin
      prev_q <= lamps_q;
      vld_q  <= {vld_q[0], 1'b1};
    end
  assign smp_vld = vld_q[1] && (lamps_q == prev_q);
`else
  logic vld_q;
  // marks the lamp register as holding a real sample rather than its reset value
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) vld_q <= 1'b0;
    else vld_q <= 1'b1;
  assign smp_vld = vld_q;
`endif
  // decode the registered lamp pattern into a phase code
  always_comb begin
    legal = 1'b1;
    dec   = state_q;
    case (lamps_q)
      6'b100100: dec = C_ST;
      6'b001100: dec = C_NS;
      6'b010100: dec = C_NY;
      6'b100001: dec = C_EW;
      6'b100010: dec = C_EY;
      default:   legal = 1'b0;
    endcase
  end
  // transition legality, dwell checks, counter, fault priority and FSM next state
  always_comb begin
    nxt    = state_q == C_ST ? C_NS : state_q == C_NS ? C_NY : state_q == C_NY ? C_EW : state_q == C_EW ? C_EY : C_NS;
    exp_t  = state_q == C_NS ? NS_T : state_q == C_EW ? EW_T : Y_T;
    chk_en = fsm_q == CHECK && state_q != C_ST;
    acc    = smp_vld && legal && (fsm_q == WAIT || dec != state_q);
    f1     = smp_vld && !legal;
    f2     = acc && fsm_q != WAIT && dec != nxt;
    f3     = acc && chk_en && cnt_q < exp_t - TOL_T;
    f4     = !acc && chk_en && i_tick && cnt_q == exp_t + TOL_T;
    ncode  = f1 ? 3'd1 : f2 ? 3'd2 : f3 ? 3'd3 : f4 ? 3'd4 : 3'd0;
    cnt_d  = acc ? '0 : (i_tick && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    state_d = acc ? dec : state_q;
    fsm_d  = !acc ? fsm_q : fsm_q == WAIT ? FIRST : CHECK;
    fault_d = (fault_q && !i_clr) || (f1 || f2 || f3 || f4);
    code_d = (fault_q && !i_clr) ? code_q : ncode;
  end
  // state registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      lamps_q  <= '0;
      fsm_q    <= WAIT;
      state_q  <= C_ST;
      change_q <= 1'b0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      lamps_q  <= i_lamps;
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      change_q <= acc;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  assign o_state      = state_q;
  assign o_change     = change_q;
  assign o_phase_time = cnt_q;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;
endmodule
